// File: rtl/ibwt_top_if.sv
// Block-level handshake bundle for the inverse BWT engine: level start,
// BWT column in, decoded string out, and the three status flags.
interface ibwt_top_if #(
    parameter int STRING_LEN = 32
);
    logic                      start;
    logic [8*STRING_LEN-1:0]   input_string_char;
    logic [8*STRING_LEN-1:0]   output_string_char;
    logic                      valid_out;
    logic                      busy;
    logic                      error;

    modport master (
        output start,
        output input_string_char,
        input  output_string_char,
        input  valid_out,
        input  busy,
        input  error
    );

    modport slave (
        input  start,
        input  input_string_char,
        output output_string_char,
        output valid_out,
        output busy,
        output error
    );
endinterface

// File: rtl/ibwt_top.sv
// Inverse Burrows-Wheeler transform: ranks every byte of L to build the
// LF map, then walks it backwards from the sentinel row to rebuild S.
module ibwt_top #(
    parameter int          STRING_LEN = 32,
    parameter logic [7:0]  SENTINEL   = 8'h24
) (
    input  logic      clk,
    input  logic      rst,
    ibwt_top_if.slave bus
);
    localparam int N  = STRING_LEN;
    localparam int IW = $clog2(N);
    localparam logic [IW:0]   ONE_W = 1;
    localparam logic [IW-1:0] ONE_I = 1;

    typedef enum logic [2:0] {IDLE, LOAD, RANK, WALK, DONE} state_t;

    state_t          state, state_next;
    logic [7:0]      l_mem  [N];
    logic [IW-1:0]   lf_mem [N];
    logic [7:0]      s_mem  [N];
    logic [IW-1:0]   idx, r, k;
    logic [IW:0]     sent_cnt;

    logic [IW:0]     rank_sum;
    logic [IW:0]     sent_cnt_next;
    logic            rank_last, walk_last;
    logic [8*N-1:0]  s_final;

    // NOTE: every variable driven here gets a default before the loop, so no latch is inferred.
    always_comb begin
        rank_sum = '0;
        for (int j = 0; j < N; j++) begin
            if (l_mem[j] < l_mem[idx] || (j < int'(idx) && l_mem[j] == l_mem[idx]))
                rank_sum = rank_sum + ONE_W;
        end
        sent_cnt_next = sent_cnt + ((l_mem[idx] == SENTINEL) ? ONE_W : '0);
        rank_last     = (idx == IW'(N-1));
        walk_last     = (k == '0);
    end

    // Byte 0 is the last one written by the walk, so it is taken straight from L[r].
    always_comb begin
        s_final = '0;
        for (int m = 0; m < N; m++) begin
            if (m == N-1)  s_final[8*m +: 8] = SENTINEL;
            else if (m == 0) s_final[8*m +: 8] = l_mem[r];
            else           s_final[8*m +: 8] = s_mem[m];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.start) state_next = LOAD;
            LOAD: state_next = RANK;
            RANK: if (rank_last) state_next = (sent_cnt_next == ONE_W) ? WALK : DONE;
            WALK: if (walk_last) state_next = DONE;
            DONE: if (bus.valid_out && !bus.start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == LOAD) || (state == RANK) || (state == WALK);
    end

    // NOTE: the small L/lf/S arrays are cleared by reset so an abandoned block leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                l_mem[i]  <= '0;
                lf_mem[i] <= '0;
                s_mem[i]  <= '0;
            end
            idx                    <= '0;
            r                      <= '0;
            k                      <= '0;
            sent_cnt               <= '0;
            bus.valid_out          <= 1'b0;
            bus.error              <= 1'b0;
            bus.output_string_char <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.valid_out          <= 1'b0;
                    bus.error              <= 1'b0;
                    bus.output_string_char <= '0;
                end
                LOAD: begin
                    for (int i = 0; i < N; i++) l_mem[i] <= bus.input_string_char[8*i +: 8];
                    idx      <= '0;
                    sent_cnt <= '0;
                end
                RANK: begin
                    lf_mem[idx] <= rank_sum[IW-1:0];
                    sent_cnt    <= sent_cnt_next;
                    idx         <= idx + ONE_I;
                    if (rank_last) begin
                        r         <= '0;
                        k         <= IW'(N-2);
                        bus.error <= (sent_cnt_next != ONE_W);
                    end
                end
                WALK: begin
                    s_mem[k] <= l_mem[r];
                    r        <= lf_mem[r];
                    if (walk_last) begin
                        bus.output_string_char <= s_final;
                        bus.valid_out          <= 1'b1;
                    end else begin
                        k <= k - ONE_I;
                    end
                end
                DONE: begin
                    // Only the error path arrives here without valid_out already set.
                    if (!bus.valid_out) begin
                        bus.valid_out          <= 1'b1;
                        bus.output_string_char <= '0;
                    end else if (!bus.start) begin
                        bus.valid_out          <= 1'b0;
                        bus.error              <= 1'b0;
                        bus.output_string_char <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ibwt_top.sv
// Directed and random checks of ibwt_top against a forward-BWT reference:
// decoding BWT(S) must give back S.
module tb_ibwt_top;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ibwt_top_if #(.STRING_LEN(32)) bus32 ();
    ibwt_top_if #(.STRING_LEN(4))  bus4 ();

    ibwt_top #(.STRING_LEN(32), .SENTINEL(8'h24)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
    ibwt_top #(.STRING_LEN(4),  .SENTINEL(8'h24)) dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: forward BWT by sorting all rotations of s.
    function automatic logic rot_less(input logic [7:0] s [32], input int a, input int b);
        for (int t = 0; t < 32; t++) begin
            if (s[(a+t)%32] != s[(b+t)%32]) return s[(a+t)%32] < s[(b+t)%32];
        end
        return 1'b0;
    endfunction

    function automatic logic [255:0] bwt32(input logic [7:0] s [32]);
        int order [32];
        logic [255:0] res;
        for (int i = 0; i < 32; i++) order[i] = i;
        for (int i = 1; i < 32; i++) begin
            int cur = order[i];
            int p = i - 1;
            while (p >= 0 && rot_less(s, cur, order[p])) begin
                order[p+1] = order[p];
                p--;
            end
            order[p+1] = cur;
        end
        res = '0;
        for (int i = 0; i < 32; i++) res[8*i +: 8] = s[(order[i]+31)%32];
        return res;
    endfunction

    function automatic logic [255:0] pack32(input logic [7:0] s [32]);
        logic [255:0] res;
        for (int i = 0; i < 32; i++) res[8*i +: 8] = s[i];
        return res;
    endfunction

    task automatic run32(input logic [255:0] l, output int edge_idx);
        @(negedge clk);
        bus32.input_string_char = l;
        bus32.start = 1'b1;
        edge_idx = -1;
        for (int e = 0; e < 200; e++) begin
            @(posedge clk); #1;
            if (bus32.valid_out) begin
                edge_idx = e;
                break;
            end
        end
    endtask

    task automatic run4(input logic [31:0] l, output int edge_idx);
        @(negedge clk);
        bus4.input_string_char = l;
        bus4.start = 1'b1;
        edge_idx = -1;
        for (int e = 0; e < 50; e++) begin
            @(posedge clk); #1;
            if (bus4.valid_out) begin
                edge_idx = e;
                break;
            end
        end
    endtask

    task automatic drop32(input string tag);
        @(negedge clk);
        bus32.start = 1'b0;
        @(posedge clk); #1;
        check({tag, "_drop_valid"}, bus32.valid_out, 1'b0);
        check({tag, "_drop_out"}, bus32.output_string_char, '0);
    endtask

    function automatic void rand_string(output logic [7:0] s [32]);
        for (int i = 0; i < 31; i++) s[i] = 8'($urandom_range(255, 37));
        s[31] = 8'h24;
    endfunction

    initial begin
        logic [7:0]   s [32];
        logic [255:0] l, exp_out, held;
        int           lat;

        bus32.start = 1'b0; bus32.input_string_char = '0;
        bus4.start  = 1'b0; bus4.input_string_char  = '0;
        #12;
        check("rst_valid", bus32.valid_out, 1'b0);
        check("rst_busy",  bus32.busy, 1'b0);
        check("rst_error", bus32.error, 1'b0);
        check("rst_out",   bus32.output_string_char, '0);
        check("rst_out4",  bus4.output_string_char, '0);
        @(negedge clk);
        rst = 1'b0;

        // N=4, L="bca$" -> "cab$"
        run4(32'h24616362, lat);
        check("n4_latency", lat, 8);
        check("n4_out",     bus4.output_string_char, 32'h24626163);
        check("n4_error",   bus4.error, 1'b0);
        check("n4_busy",    bus4.busy, 1'b0);
        @(negedge clk); bus4.start = 1'b0;
        @(posedge clk); #1;
        check("n4_drop_valid", bus4.valid_out, 1'b0);

        // 31 x 'a' then '$'
        l = {8'h24, {31{8'h61}}};
        run32(l, lat);
        check("aaa_latency", lat, 64);
        check("aaa_out",     bus32.output_string_char, l);
        check("aaa_error",   bus32.error, 1'b0);

        // Holding start keeps the result stable
        held = bus32.output_string_char;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("hold_valid", bus32.valid_out, 1'b1);
            check("hold_out",   bus32.output_string_char, held);
        end
        drop32("hold");

        // Fresh decode after re-raising start
        rand_string(s);
        run32(bwt32(s), lat);
        check("fresh_latency", lat, 64);
        check("fresh_out",     bus32.output_string_char, pack32(s));
        drop32("fresh");

        // Two sentinels -> error path
        l = {31{8'h61}};
        l = {8'h61, l[247:0]};
        l[7:0]   = 8'h24;
        l[47:40] = 8'h24;
        run32(l, lat);
        check("err_latency", lat, 34);
        check("err_flag",    bus32.error, 1'b1);
        check("err_out",     bus32.output_string_char, '0);
        drop32("err");
        check("err_cleared", bus32.error, 1'b0);

        // Loopback through the reference forward BWT
        for (int v = 0; v < 200; v++) begin
            rand_string(s);
            exp_out = pack32(s);
            run32(bwt32(s), lat);
            check("loop_latency", lat, 64);
            check("loop_out",     bus32.output_string_char, exp_out);
            check("loop_error",   bus32.error, 1'b0);
            drop32("loop");
        end

        // Reset in the middle of WALK
        rand_string(s);
        @(negedge clk);
        bus32.input_string_char = bwt32(s);
        bus32.start = 1'b1;
        repeat (46) @(posedge clk);
        #1;
        check("mid_busy",  bus32.busy, 1'b1);
        check("mid_valid", bus32.valid_out, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", bus32.valid_out, 1'b0);
        check("arst_busy",  bus32.busy, 1'b0);
        check("arst_error", bus32.error, 1'b0);
        check("arst_out",   bus32.output_string_char, '0);
        bus32.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rand_string(s);
        run32(bwt32(s), lat);
        check("post_rst_latency", lat, 64);
        check("post_rst_out",     bus32.output_string_char, pack32(s));
        drop32("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
